dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store initiator between the MEM pipeline stage and dataMem. Accepts
//  byte/half/word loads and stores on byte addresses and drives dataMem's
//  word-addressed addr/memRead/memWrite/data_in, consuming its registered
//  1-cycle read data. Sub-word stores use read-modify-write. Misaligned or
//  out-of-range requests are rejected without touching memory.
// PARAMETERS
//  MEM_AW     11    word-address width driven to dataMem
//  MEM_DEPTH  2048  words in dataMem; word index >= MEM_DEPTH is out of range
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   unit idle; request accepted on edge with valid&ready
//  req_write    in   1   1=store, 0=load
//  req_size     in   2   00=byte, 01=half, 10=word, 11=illegal (error)
//  req_signed   in   1   loads: 1=sign-extend, 0=zero-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid   out  1   one-cycle pulse: request completed
//  resp_err     out  1   valid with resp_valid: misaligned/out-of-range/illegal
//  resp_rdata   out  32  load result, extended; 0 for stores and errors
//  mem_addr     out  32  word index (byte_addr>>2) to dataMem addr; upper bits 0
//  mem_wdata    out  32  to dataMem data_in
//  mem_rdata    in   32  from dataMem data_out (valid the cycle after memRead)
//  mem_read     out  1   to dataMem memRead
//  mem_write    out  1   to dataMem memWrite
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write=0;
//    resp_rdata, mem_addr, mem_wdata=0. All outputs registered except req_ready
//    (decoded from state==IDLE).
//  - Little-endian lanes: byte addr[1:0]=n -> bits [8n+7:8n]; half addr[1]=h ->
//    bits [16h+15:16h].
//  - Error check at accept: half with addr[0]=1, word with addr[1:0]!=0,
//    size=11, or addr[31:2]>=MEM_DEPTH. -> state ERR; no mem_read/mem_write ever
//    asserted; resp_valid=1, resp_err=1, resp_rdata=0 after edge k+1.
//  - States: IDLE, RD (mem_read=1), RDW (wait data), RMW_RD (mem_read=1),
//    RMW_MRG (wait data), WR (mem_write=1), ERR. Request accepted on edge k:
//    load       IDLE->RD->RDW->IDLE; mem_read high k..k+1; dataMem captures at
//               k+1; resp_rdata extracted from mem_rdata at k+2; resp_valid k+2.
//    word store IDLE->WR->IDLE; mem_write high k..k+1, mem_wdata=req_wdata;
//               write lands at k+1; resp_valid k+1.
//    sub-word   IDLE->RMW_RD->RMW_MRG->WR->IDLE; read word at k+1; merged
//    store      word (only addressed lane replaced) registered to mem_wdata at
//               k+2; write lands at k+3; resp_valid k+3.
//  - resp_valid is a single-cycle pulse, coinciding with return to IDLE, so
//    req_ready=1 in the same cycle and back-to-back requests lose no cycle.
//  - req_* sampled only at accept; later changes ignored. mem_addr held for
//    the whole transaction. mem_read and mem_write never both high.
//  - req_valid while not ready: ignored, no buffering (pipeline stalls on
//    ~req_ready).
//  - rst mid-transaction: abort to IDLE at that edge, no resp_valid. If rst
//    coincides with the WR cycle, dataMem still writes at that edge (dataMem
//    write path has no reset); caller must treat the store as indeterminate.
// TESTING
//  1 Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_addr=4,
//    resp_valid at k+1 (store) and k+2 (load), resp_rdata=0xDEADBEEF.
//  2 Byte store 0xAB @0x13 over word 0x11223344 -> RMW, mem_wdata=0xAB223344
//    at k+2, resp_valid k+3; signed byte load @0x13 -> 0xFFFFFFAB.
//  3 Half loads @0x12 of 0x8001_xxxx: unsigned -> 0x00008001, signed -> 0xFFFF8001.
//  4 Word load @0x2, half store @0x1, size=11, addr=0x2000 -> resp_err=1
//    at k+1, mem_read/mem_write never asserted.
//  5 Back-to-back load, store, load with req_valid held -> each accepted the
//    cycle resp_valid of the prior fires; data/order correct.
//  6 rst asserted in RMW_MRG -> IDLE next cycle, no resp_valid, no mem_write;
//    target word unchanged on readback.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store initiator between the MEM stage and a word-addressed dataMem with
// 1-cycle registered read data. Sub-word stores use read-modify-write. Misaligned,
// out-of-range and illegal-size requests complete with an error and never touch memory.
module dmem_lsu #(
  parameter int unsigned MEM_AW    = 11,
  parameter int unsigned MEM_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write
);

  typedef enum logic [2:0] {
    StIdle, StRd, StRdw, StRmwRd, StRmwMrg, StWr, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;

  logic        resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [31:0] resp_rdata_d, mem_addr_d, mem_wdata_d;

  logic        req_err;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign req_ready = (state_q == StIdle);

  // Reject at accept: misaligned half/word, illegal size, or word index beyond memory.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_DEPTH) req_err = 1'b1;
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    byte_v   = mem_rdata[{lane_q, 3'b000} +: 8];
    half_v   = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    merged   = mem_rdata;
    case (size_q)
      2'b00: begin
        load_ext = {{24{signed_q & byte_v[7]}}, byte_v};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_ext = {{16{signed_q & half_v[15]}}, half_v};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  // Next-state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata[15:0];
          if (req_err) begin
            state_d = StErr;
          end else begin
            mem_addr_d = {{(32 - MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
            if (req_write && req_size == 2'b10) begin
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata;
              state_d     = StWr;
            end else if (req_write) begin
              mem_read_d = 1'b1;
              state_d    = StRmwRd;
            end else begin
              mem_read_d = 1'b1;
              state_d    = StRd;
            end
          end
        end
      end
      StRd:    state_d = StRdw;
      StRdw: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
        state_d      = StIdle;
      end
      StRmwRd: state_d = StRmwMrg;
      StRmwMrg: begin
        mem_wdata_d = merged;
        mem_write_d = 1'b1;
        state_d     = StWr;
      end
      StWr: begin
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end
      StErr: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a dataMem stand-in with registered reads, plus a
// request-level reference model (shadow memory and arithmetic lane rules).
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_read, mem_write;

  logic [31:0] dmem [DEPTH] = '{default: 32'h0};
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_AW(11), .MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write)
  );

  // dataMem stand-in: synchronous write, registered 1-cycle read.
  always @(posedge clk) begin
    if (mem_write && mem_addr < DEPTH) dmem[mem_addr[10:0]] <= mem_wdata;
    if (mem_read && mem_addr < DEPTH) mem_rdata <= dmem[mem_addr[10:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Issue one request at a negedge with the unit idle; follow it to its response.
  // With garbage set, req_valid stays high with random fields while busy.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit garbage);
    logic [31:0] idx, old, exp_rdata, new_word, mask, v;
    int sh, exp_lat, seen;
    bit err, exp_rd, exp_wr;
    idx = a >> 2;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
          (idx >= DEPTH);
    old       = err ? 32'h0 : ref_mem[idx[10:0]];
    exp_rdata = 32'h0;
    new_word  = old;
    if (err) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 2;
      if (sz == 2'd0) begin
        sh = 8 * int'(a[1:0]);
        v = (old >> sh) & 32'hFF;
        if (sg && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        sh = 16 * int'(a[1]);
        v = (old >> sh) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v | 32'hFFFF0000;
      end else begin
        v = old;
      end
      exp_rdata = v;
    end else if (sz == 2'd2) begin
      exp_lat  = 1;
      new_word = wd;
    end else begin
      exp_lat = 3;
      if (sz == 2'd0) begin
        sh = 8 * int'(a[1:0]);
        mask = 32'hFF << sh;
        new_word = (old & ~mask) | ((wd & 32'hFF) << sh);
      end else begin
        sh = 16 * int'(a[1]);
        mask = 32'hFFFF << sh;
        new_word = (old & ~mask) | ((wd & 32'hFFFF) << sh);
      end
    end

    check_eq("ready_at_issue", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    seen = -1;
    for (int ph = 0; ph < 8; ph++) begin
      @(negedge clk);
      if (ph == 0) begin
        if (garbage) begin
          req_write  = 1'($urandom);
          req_size   = 2'($urandom);
          req_signed = 1'($urandom);
          req_addr   = $urandom;
          req_wdata  = $urandom;
        end else begin
          req_valid = 1'b0;
        end
      end
      exp_rd = !err && !(w && sz == 2'd2) && ph == 0;
      exp_wr = !err && w && ((sz == 2'd2 && ph == 0) || (sz != 2'd2 && ph == 2));
      check_eq("mem_read", {31'b0, mem_read}, {31'b0, exp_rd});
      check_eq("mem_write", {31'b0, mem_write}, {31'b0, exp_wr});
      if (exp_rd || exp_wr) check_eq("mem_addr", mem_addr, idx);
      if (exp_wr) check_eq("mem_wdata", mem_wdata, new_word);
      if (resp_valid) begin
        seen = ph;
        break;
      end
    end
    if (seen < 0) begin
      check_eq("resp_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("latency", 32'(seen), 32'(exp_lat));
      check_eq("resp_err", {31'b0, resp_err}, {31'b0, err});
      check_eq("resp_rdata", resp_rdata, exp_rdata);
      check_eq("ready_at_resp", {31'b0, req_ready}, 32'd1);
    end
    if (!err && w) ref_mem[idx[10:0]] = new_word;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] idx, a;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check_eq("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Word store/load round trip.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    // Byte RMW store, then signed byte load.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0);
    run_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 1'b0);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
    // Half loads, unsigned and signed.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80015566, 1'b0);
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
    run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    // Error cases.
    run_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1'b0);
    run_req(1'b1, 2'd1, 1'b0, 32'h1, 32'h1234, 1'b0);
    run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
    run_req(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 1'b0);
    // Back-to-back load, store, load with valid held.
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    run_req(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000BEEF, 1'b1);
    run_req(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 1'b0);

    // Fill a small window, then random traffic over it.
    for (int i = 0; i < 32; i++) run_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0);
    for (int i = 0; i < 300; i++) begin
      sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      idx = ($urandom_range(0, 15) == 0) ? 32'(DEPTH + $urandom_range(0, 100))
                                         : 32'($urandom_range(0, 31));
      a = idx * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom, bit'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;

    // Reset during the merge wait of a byte store must drop it entirely.
    run_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0);
    check_eq("ready_before_abort", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h41;
    req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("abort_no_resp", {31'b0, resp_valid}, 32'd0);
      check_eq("abort_no_write", {31'b0, mem_write}, 32'd0);
      @(negedge clk);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
